// File: rtl/serial_cmp_ctrl.sv
// Bit-serial unsigned magnitude comparator controller, MSB first, one bit per clock.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish on the first differing bit instead of running constant-time.

module bit_cmp (
   input  logic a,
   input  logic b,
   output logic gt,
   output logic eq,
   output logic lt
);
   assign gt = a & ~b;
   assign lt = ~a & b;
   assign eq = ~(a ^ b);
endmodule

module serial_cmp_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             greater,
   output logic             equal,
   output logic             less,
   output logic             busy
);
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             greater_r;
   logic             less_r;
   logic             equal_r;
   logic             cmp_gt;
   logic             cmp_eq;
   logic             cmp_lt;
   logic             decided;
   logic             done_now;

   bit_cmp u_bit_cmp (
      .a  (a_reg[idx]),
      .b  (b_reg[idx]),
      .gt (cmp_gt),
      .eq (cmp_eq),
      .lt (cmp_lt)
   );

   // Once a differing bit has been seen, later bits must not disturb the verdict.
   assign decided = greater_r | less_r;

   always_comb begin
      done_now = (idx == '0);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      if (!decided && !cmp_eq)
         done_now = 1'b1;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         greater_r <= 1'b0;
         less_r    <= 1'b0;
         equal_r   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg     <= a_in;
                  b_reg     <= b_in;
                  idx       <= IW'(WIDTH - 1);
                  greater_r <= 1'b0;
                  less_r    <= 1'b0;
                  equal_r   <= 1'b0;
                  state     <= RUN;
               end
            end
            RUN: begin
               if (!decided) begin
                  greater_r <= cmp_gt;
                  less_r    <= cmp_lt;
               end
               if (done_now) begin
                  equal_r <= !decided && cmp_eq;
                  state   <= DONE;
               end else begin
                  idx <= idx - IW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  greater_r <= 1'b0;
                  less_r    <= 1'b0;
                  equal_r   <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Flags accumulate during RUN but are only exposed alongside out_valid.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == RUN) || (state == DONE);
   assign greater   = greater_r & out_valid;
   assign less      = less_r & out_valid;
   assign equal     = equal_r & out_valid;
endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Scoreboard bench for serial_cmp_ctrl at WIDTH=8; expected latency follows SERIAL_CMP_EARLY_EXIT_EN.

module tb_serial_cmp_ctrl;
   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         out_valid;
   logic         out_ready;
   logic         greater;
   logic         equal;
   logic         less;
   logic         busy;

   typedef struct {
      logic g;
      logic e;
      logic l;
      int   lat;
   } exp_t;

   exp_t expQ[$];
   exp_t cur;
   int   testsRun;
   int   testsFailed;
   int   cyc;
   int   acceptEdge;
   logic prevValid;

   serial_cmp_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_in      (a_in),
      .b_in      (b_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .greater   (greater),
      .equal     (equal),
      .less      (less),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int required);
      testsRun++;
      if (actual != required) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, required, $time);
      end
   endtask

   // Monitor: tracks accepts, pops the scoreboard on each new result and checks the hold phase.
   always @(negedge clk) begin
      if (rst_n && in_valid && in_ready)
         acceptEdge = cyc + 1;
      if (out_valid && !prevValid) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_out_valid", 1, 0);
         end else begin
            cur = expQ.pop_front();
            checkOutput("greater", int'(greater), int'(cur.g));
            checkOutput("equal", int'(equal), int'(cur.e));
            checkOutput("less", int'(less), int'(cur.l));
            checkOutput("latency", cyc - acceptEdge, cur.lat);
            checkOutput("busy_done", int'(busy), 1);
         end
      end else if (out_valid && prevValid) begin
         checkOutput("hold_flags", int'({greater, equal, less}), int'({cur.g, cur.e, cur.l}));
         checkOutput("hold_in_ready", int'(in_ready), 0);
      end else if (!out_valid) begin
         checkOutput("flags_idle", int'({greater, equal, less}), 0);
      end
      prevValid = out_valid;
   end

   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic g, input logic e, input logic l,
                                input int latEarly, input int hold, input bit junk);
      exp_t x;
      int   n;
      x.g = g; x.e = e; x.l = l;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      x.lat = latEarly;
`else
      x.lat = W;
`endif
      expQ.push_back(x);
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) checkOutput("wait_in_ready_timeout", 0, 1);
      in_valid = 1'b1;
      a_in = a;
      b_in = b;
      @(posedge clk); #1;
      n = 0;
      while (!out_valid && n < 40) begin
         if (junk) begin
            a_in = a_in + 8'h37;
            b_in = ~b_in;
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      if (!out_valid) checkOutput("wait_out_valid_timeout", 0, 1);
      repeat (hold) begin
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkOutput("idle_in_ready", int'(in_ready), 1);
      checkOutput("idle_out_valid", int'(out_valid), 0);
      checkOutput("idle_busy", int'(busy), 0);
   endtask

   initial begin
      int n;
      testsRun = 0;
      testsFailed = 0;
      cyc = 0;
      acceptEdge = 0;
      prevValid = 1'b0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a_in = '0;
      b_in = '0;
      #12;
      checkOutput("reset_in_ready", int'(in_ready), 1);
      checkOutput("reset_out_valid", int'(out_valid), 0);
      checkOutput("reset_busy", int'(busy), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      applyStimulus(8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0, 8, 0, 1'b0);
      applyStimulus(8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0);
      applyStimulus(8'h12, 8'h13, 1'b0, 1'b0, 1'b1, 8, 0, 1'b0);
      applyStimulus(8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0);
      applyStimulus(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1, 5, 1'b0);
      applyStimulus(8'h10, 8'h08, 1'b1, 1'b0, 1'b0, 4, 2, 1'b0);
      applyStimulus(8'h3C, 8'h3D, 1'b0, 1'b0, 1'b1, 8, 1, 1'b1);

      // Abort a compare in flight; no result may appear for it.
      in_valid = 1'b1;
      a_in = 8'h01;
      b_in = 8'h00;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      checkOutput("mid_run_busy", int'(busy), 1);
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_in_ready", int'(in_ready), 1);
      checkOutput("abort_busy", int'(busy), 0);
      checkOutput("abort_flags", int'({out_valid, greater, equal, less}), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (12) begin
         @(posedge clk); #1;
      end
      checkOutput("abort_no_result", int'(out_valid), 0);

      applyStimulus(8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 8, 0, 1'b0);
      applyStimulus(8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 8, 0, 1'b1);

      n = 0;
      while (expQ.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("scoreboard_drained", expQ.size(), 0);
      @(posedge clk); #1;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule

// File: doc/serial_cmp_ctrl.md
SERIAL_CMP_CTRL -- requirements
Module: serial_cmp_ctrl

Interface
REQ-001: Parameter WIDTH, default 32, operand width in bits; legal range 1..256.
REQ-002: clk  input  1  rising-edge clock for all state.
REQ-003: rst_n  input  1  asynchronous, active-low reset.
REQ-004: in_valid  input  1  operand pair a_in/b_in presented.
REQ-005: in_ready  output  1  controller accepts an operand pair this cycle.
REQ-006: a_in  input  WIDTH  operand A, unsigned.
REQ-007: b_in  input  WIDTH  operand B, unsigned.
REQ-008: out_valid  output  1  result flags valid.
REQ-009: out_ready  input  1  consumer takes the result this cycle.
REQ-010: greater  output  1  A > B.
REQ-011: equal  output  1  A == B.
REQ-012: less  output  1  A < B.
REQ-013: busy  output  1  high in RUN and DONE.

Function
REQ-014: The block SHALL compare operands bit-serially, MSB first, through one instance of the team's 1-bit comparator module, with one bit per clock.
REQ-015: States SHALL be IDLE, RUN and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016: IDLE to RUN SHALL happen on in_valid&&in_ready: capture a_in and b_in into registers, set bit index to WIDTH-1, clear result flags.
REQ-017: In RUN, each clock SHALL feed captured bit[idx] of A and B to the comparator and decrement idx; the index counter width SHALL be $clog2(WIDTH), minimum 1.
REQ-018: The first differing bit SHALL set greater or less from the comparator outputs; once set, flags SHALL NOT change until the next accept.
REQ-019: RUN to DONE SHALL occur after the bit at idx==0 is processed, or earlier per REQ-028; if no bit differed, equal=1.
REQ-020: Exactly one of greater/equal/less SHALL be high whenever out_valid=1; all three SHALL be 0 otherwise.
REQ-021: In DONE, flags SHALL be held stable while out_ready=0; on out_ready=1 the state SHALL return to IDLE and the flags clear on that edge.
REQ-022: in_valid during RUN or DONE SHALL be ignored; no operand is captured; no overlap of transactions.
REQ-023: Latency without early exit SHALL be WIDTH clocks from the accept edge to out_valid high.
REQ-024: WIDTH=1 SHALL work: one RUN cycle, then DONE.

Reset
REQ-025: rst_n low SHALL immediately force state IDLE, idx=0, and operand registers, flags, out_valid and busy to 0; in_ready SHALL be 1 while in reset and after reset.
REQ-026: Reset asserted mid-RUN or in DONE SHALL abort the transaction with no result produced; the first in_valid after release SHALL start a fresh compare.

Configuration
REQ-027: Macro SERIAL_CMP_EARLY_EXIT_EN SHALL select early termination.
REQ-028: When the macro is defined, RUN SHALL go to DONE on the clock that processes the first differing bit, giving latency = (WIDTH - index of the first differing bit) clocks; the equal case stays at WIDTH clocks.
REQ-029: When the macro is undefined, latency SHALL always be WIDTH clocks, independent of operand values (constant-time).

Verification (WIDTH=8)
REQ-030: a=0xA5, b=0xA5 -> equal=1, greater=less=0, out_valid 8 clocks after accept, either build.
REQ-031: a=0x80, b=0x7F -> greater=1; out_valid 1 clock after accept with SERIAL_CMP_EARLY_EXIT_EN defined, 8 clocks without.
REQ-032: a=0x12, b=0x13 -> less=1 at 8 clocks, both builds; a=0x00, b=0xFF -> less=1 at 1 clock (early exit) or 8 clocks.
REQ-033: Result ready with out_ready held 0 for 5 clocks -> flags and out_valid stable; in_ready stays 0; IDLE one clock after out_ready=1.
REQ-034: rst_n pulsed low mid-RUN (a=0x01, b=0x00) -> outputs 0 immediately, no out_valid, in_ready=1; next pair a=0x01, b=0x00 -> greater=1.
REQ-035: in_valid held high with changing a_in during RUN -> captured operands unaffected; back-to-back transactions accepted only in IDLE.
